trap_ctrl: RTL

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: arbitrates exceptions and interrupts, sequences handler entry/return.
// Optional macro TRAP_IRQ_SYNC_EN adds a 2-flop synchronizer on e_irq and t_irq.
module trap_ctrl (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        e_irq,
    input  logic        t_irq,
    input  logic        mie,
    input  logic        meie,
    input  logic        mtie,
    input  logic        excep_req,
    input  logic [3:0]  excep_cause_in,
    input  logic        mret,
    input  logic        i_stall,
    input  logic        instr_valid,
    output logic        intr_en,
    output logic        excep_en,
    output logic [3:0]  intr_cause,
    output logic [3:0]  exception_cause,
    output logic        flush,
    output logic        in_trap,
    output logic [15:0] trap_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HANDLER = 2'd1,
        RETURN  = 2'd2
    } state_t;

    localparam logic [3:0] CAUSE_EXT   = 4'd11;
    localparam logic [3:0] CAUSE_TIMER = 4'd7;

    state_t      state_r;
    state_t      state_next_s;
    logic        e_irq_q_s;
    logic        t_irq_q_s;
    logic        pend_e_s;
    logic        pend_t_s;
    logic        intr_en_s;
    logic        excep_en_s;
    logic [3:0]  intr_cause_s;
    logic [3:0]  exception_cause_s;
    logic        flush_s;
    logic        in_trap_r;
    logic [15:0] trap_cnt_r;

`ifdef TRAP_IRQ_SYNC_EN
    logic [1:0] e_sync_r;
    logic [1:0] t_sync_r;

    // Two-stage synchronizers for the asynchronous interrupt request lines
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            e_sync_r <= 2'b00;
            t_sync_r <= 2'b00;
        end else begin
            e_sync_r <= {e_sync_r[0], e_irq};
            t_sync_r <= {t_sync_r[0], t_irq};
        end
    end

    assign e_irq_q_s = e_sync_r[1];
    assign t_irq_q_s = t_sync_r[1];
`else
    assign e_irq_q_s = e_irq;
    assign t_irq_q_s = t_irq;
`endif

    assign pend_e_s = e_irq_q_s & meie;
    assign pend_t_s = t_irq_q_s & mtie;

    // Next-state and trap-take decision; everything is forced quiet while reset is high
    always_comb begin
        state_next_s      = state_r;
        intr_en_s         = 1'b0;
        excep_en_s        = 1'b0;
        intr_cause_s      = 4'd0;
        exception_cause_s = 4'd0;
        flush_s           = 1'b0;
        if (i_rst) begin
            state_next_s = IDLE;
        end else if (i_stall) begin
            state_next_s = state_r;
        end else begin
            case (state_r)
                IDLE: begin
                    if (excep_req) begin
                        excep_en_s        = 1'b1;
                        exception_cause_s = excep_cause_in;
                        flush_s           = 1'b1;
                        state_next_s      = HANDLER;
                    end else if (mie && instr_valid && (pend_e_s || pend_t_s)) begin
                        intr_en_s    = 1'b1;
                        intr_cause_s = pend_e_s ? CAUSE_EXT : CAUSE_TIMER;
                        flush_s      = 1'b1;
                        state_next_s = HANDLER;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                HANDLER: begin
                    // A nested exception outranks a simultaneous mret
                    if (excep_req) begin
                        excep_en_s        = 1'b1;
                        exception_cause_s = excep_cause_in;
                        flush_s           = 1'b1;
                        state_next_s      = HANDLER;
                    end else if (mret) begin
                        state_next_s = RETURN;
                    end else begin
                        state_next_s = HANDLER;
                    end
                end
                RETURN: begin
                    flush_s      = 1'b1;
                    state_next_s = IDLE;
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // State register plus in_trap, which tracks whether the next state is inside a handler
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r   <= IDLE;
            in_trap_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            in_trap_r <= (state_next_s != IDLE);
        end
    end

    // Saturating count of traps taken
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            trap_cnt_r <= 16'd0;
        end else if ((intr_en_s || excep_en_s) && (trap_cnt_r != 16'hFFFF)) begin
            trap_cnt_r <= trap_cnt_r + 16'd1;
        end else begin
            trap_cnt_r <= trap_cnt_r;
        end
    end

    assign intr_en         = intr_en_s;
    assign excep_en        = excep_en_s;
    assign intr_cause      = intr_cause_s;
    assign exception_cause = exception_cause_s;
    assign flush           = flush_s;
    assign in_trap         = in_trap_r;
    assign trap_cnt        = trap_cnt_r;

endmodule
